// File: rtl/aes_128_key_bank.sv
// Purpose: holds NUM_BANKS AES-128 round-key sets (11 x 128b), filled in beats, read by round index from the active bank.
// Latency: rd_key registered one cycle after rd_round; wr_done_pulse / key_err_irq_pulse one cycle after the causing event.
// Backpressure: none; every beat or switch request is either taken or rejected with key_err_irq_pulse.
module aes_128_key_bank #(
    parameter int  NUM_BANKS = 2,
    parameter int  WR_WIDTH  = 64,
    localparam int BW        = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 kill_n,
    input  logic                 en_wr,
    input  logic [WR_WIDTH-1:0]  key_round_wr,
    input  logic [BW-1:0]        wr_bank,
    input  logic                 switch_key,
    input  logic [BW-1:0]        sel_bank,
    input  logic                 busy,
    input  logic [3:0]           rd_round,
    output logic [127:0]         rd_key,
    output logic [BW-1:0]        active_bank,
    output logic [NUM_BANKS-1:0] bank_valid,
    output logic                 switch_pending,
    output logic                 wr_done_pulse,
    output logic                 key_err_irq_pulse
);

    localparam int         BEATS      = 1408 / WR_WIDTH;
    localparam int         WPK        = 128 / WR_WIDTH;
    localparam int         CW         = $clog2(BEATS);
    localparam int         DEPTH      = NUM_BANKS * BEATS;
    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } wr_state_e;

    wr_state_e            state_q, state_d;
    logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]        fill_bank_q, fill_bank_d;
    logic [NUM_BANKS-1:0] bank_valid_q, bank_valid_d;
    logic [BW-1:0]        active_bank_q, active_bank_d;
    logic [BW-1:0]        pend_bank_q, pend_bank_d;
    logic                 switch_pending_q, switch_pending_d;
    logic                 wr_done_q, wr_done_d;
    logic                 key_err_q, key_err_d;
    logic [127:0]         rd_key_q, rd_key_d;

    // Key storage: one WR_WIDTH word per beat, banks laid out back to back.
    logic [WR_WIDTH-1:0]  key_mem_q [DEPTH];

    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic                 wr_first_acc;
    logic                 wr_reject;
    logic                 sw_reject;
    logic [3:0]           rd_round_c;
    logic [AW-1:0]        rd_base;

    // Banks beyond NUM_BANKS exist only when NUM_BANKS is not a power of two.
    function automatic logic bank_ok(input logic [BW-1:0] b);
        return (int'(b) < NUM_BANKS);
    endfunction

    function automatic logic [AW-1:0] mem_addr(input logic [BW-1:0] b, input logic [CW-1:0] beat);
        return AW'(int'(b) * BEATS + int'(beat));
    endfunction

    // Write FSM: first beat picks and invalidates the bank, last beat revalidates it.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        fill_bank_d  = fill_bank_q;
        bank_valid_d = bank_valid_q;
        wr_done_d    = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        wr_first_acc = 1'b0;
        wr_reject    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_wr) begin
                    // The core may be reading the active bank (busy) or about to
                    // leave it (pending switch); overwriting it then is unsafe.
                    if (!bank_ok(wr_bank) ||
                        ((wr_bank == active_bank_q) && (busy || switch_pending_q))) begin
                        wr_reject = 1'b1;
                    end else begin
                        wr_first_acc           = 1'b1;
                        state_d                = S_FILL;
                        fill_bank_d            = wr_bank;
                        bank_valid_d[wr_bank]  = 1'b0;
                        beat_cnt_d             = CW'(1);
                        mem_we                 = 1'b1;
                        mem_waddr              = mem_addr(wr_bank, '0);
                    end
                end
            end
            S_FILL: begin
                if (en_wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = mem_addr(fill_bank_q, beat_cnt_q);
                    if (beat_cnt_q == CW'(BEATS - 1)) begin
                        state_d                   = S_IDLE;
                        beat_cnt_d                = '0;
                        bank_valid_d[fill_bank_q] = 1'b1;
                        wr_done_d                 = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Bank switch: immediate when idle, deferred while the core is busy.
    always_comb begin
        active_bank_d    = active_bank_q;
        switch_pending_d = switch_pending_q;
        pend_bank_d      = pend_bank_q;
        sw_reject        = 1'b0;
        if (switch_pending_q && !busy) begin
            active_bank_d    = pend_bank_q;
            switch_pending_d = 1'b0;
        end
        if (switch_key) begin
            // A bank under fill (including one whose first or last beat lands
            // this very cycle) never becomes a legal target.
            if (!bank_ok(sel_bank) || !bank_valid_q[sel_bank] ||
                ((state_q == S_FILL) && (sel_bank == fill_bank_q)) ||
                (wr_first_acc && (sel_bank == wr_bank))) begin
                sw_reject = 1'b1;
            end else if (busy) begin
                switch_pending_d = 1'b1;
                pend_bank_d      = sel_bank;
            end else begin
                // Newest request wins over any pending target.
                active_bank_d    = sel_bank;
                switch_pending_d = 1'b0;
            end
        end
    end

    // Both rejects in one cycle collapse into a single pulse.
    always_comb begin
        key_err_d = wr_reject | sw_reject;
    end

    // Round-key read: out-of-range rounds and an invalid active bank return zero.
    always_comb begin
        rd_round_c = (rd_round > LAST_ROUND) ? 4'd0 : rd_round;
        rd_base    = AW'(int'(active_bank_q) * BEATS + int'(rd_round_c) * WPK);
        rd_key_d   = '0;
        if ((rd_round <= LAST_ROUND) && bank_valid_q[active_bank_q]) begin
            for (int p = 0; p < WPK; p++) begin
                rd_key_d[p*WR_WIDTH +: WR_WIDTH] = key_mem_q[rd_base + AW'(p)];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_q          <= S_IDLE;
            beat_cnt_q       <= '0;
            fill_bank_q      <= '0;
            bank_valid_q     <= '0;
            active_bank_q    <= '0;
            pend_bank_q      <= '0;
            switch_pending_q <= 1'b0;
            wr_done_q        <= 1'b0;
            key_err_q        <= 1'b0;
            rd_key_q         <= '0;
        end else begin
            state_q          <= state_d;
            beat_cnt_q       <= beat_cnt_d;
            fill_bank_q      <= fill_bank_d;
            bank_valid_q     <= bank_valid_d;
            active_bank_q    <= active_bank_d;
            pend_bank_q      <= pend_bank_d;
            switch_pending_q <= switch_pending_d;
            wr_done_q        <= wr_done_d;
            key_err_q        <= key_err_d;
            rd_key_q         <= rd_key_d;
        end
    end

    // Key storage write; contents survive reset, bank_valid gates their use.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            key_mem_q[mem_waddr] <= key_round_wr;
        end
    end

    assign rd_key            = rd_key_q;
    assign active_bank       = active_bank_q;
    assign bank_valid        = bank_valid_q;
    assign switch_pending    = switch_pending_q;
    assign wr_done_pulse     = wr_done_q;
    assign key_err_irq_pulse = key_err_q;

endmodule

// File: tb/tb_aes_128_key_bank.sv
// Purpose: randomized and directed bench for two key-bank configs (2x64b and 4x128b) against a bank-level model.
// Latency: read expectations are queued at issue and checked one edge later by a monitor.
// Backpressure: none; the bench drives at most one operation per instance at a time.
module tb_aes_128_key_bank;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         kill_n;
    logic [1:0]   en_wr;
    logic [1:0]   sw_key;
    logic [1:0]   busy;
    logic [127:0] wr_dat;
    logic [2:0]   wr_bank;
    logic [2:0]   sel_bank;
    logic [3:0]   rd_round;
    logic [1:0]   rd_req;

    logic [127:0] rd_key_a, rd_key_b;
    logic [0:0]   act_a;
    logic [1:0]   act_b;
    logic [1:0]   vld_a;
    logic [3:0]   vld_b;
    logic         pend_a, pend_b, done_a, done_b, err_a, err_b;

    aes_128_key_bank #(.NUM_BANKS(2), .WR_WIDTH(64)) dut_a (
        .clk(clk), .kill_n(kill_n), .en_wr(en_wr[0]), .key_round_wr(wr_dat[63:0]),
        .wr_bank(wr_bank[0:0]), .switch_key(sw_key[0]), .sel_bank(sel_bank[0:0]),
        .busy(busy[0]), .rd_round(rd_round), .rd_key(rd_key_a), .active_bank(act_a),
        .bank_valid(vld_a), .switch_pending(pend_a), .wr_done_pulse(done_a),
        .key_err_irq_pulse(err_a)
    );

    aes_128_key_bank #(.NUM_BANKS(4), .WR_WIDTH(128)) dut_b (
        .clk(clk), .kill_n(kill_n), .en_wr(en_wr[1]), .key_round_wr(wr_dat),
        .wr_bank(wr_bank[1:0]), .switch_key(sw_key[1]), .sel_bank(sel_bank[1:0]),
        .busy(busy[1]), .rd_round(rd_round), .rd_key(rd_key_b), .active_bank(act_b),
        .bank_valid(vld_b), .switch_pending(pend_b), .wr_done_pulse(done_b),
        .key_err_irq_pulse(err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what each bank holds and which bank the core sees.
    logic [127:0] m_key [2][8][11];
    logic [7:0]   m_valid [2];
    int           m_active [2];
    bit           m_pend [2];
    int           m_pend_bank [2];

    logic [127:0] fill_rk [11];
    logic [7:0]   sbox [256];
    logic [127:0] exp_q0 [$];
    logic [127:0] exp_q1 [$];
    logic [1:0]   mon_req;
    logic [127:0] mon_exp;

    function automatic int wpk(input int c);  return (c == 0) ? 2 : 1; endfunction
    function automatic int nbk(input int c);  return (c == 0) ? 2 : 4; endfunction
    function automatic logic [127:0] g_rd(input int c);  return (c == 0) ? rd_key_a : rd_key_b; endfunction
    function automatic int g_act(input int c);   return (c == 0) ? int'(act_a) : int'(act_b); endfunction
    function automatic logic [7:0] g_vld(input int c); return (c == 0) ? {6'b0, vld_a} : {4'b0, vld_b}; endfunction
    function automatic logic g_pend(input int c); return (c == 0) ? pend_a : pend_b; endfunction
    function automatic logic g_done(input int c); return (c == 0) ? done_a : done_b; endfunction
    function automatic logic g_err(input int c);  return (c == 0) ? err_a : err_b; endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input int c, input string tag);
        chk($sformatf("%s active_bank[%0d]", tag, c), 128'(g_act(c)), 128'(m_active[c]));
        chk($sformatf("%s bank_valid[%0d]", tag, c), 128'(g_vld(c)), 128'(m_valid[c]));
        chk($sformatf("%s switch_pending[%0d]", tag, c), 128'(g_pend(c)), 128'(m_pend[c]));
    endtask

    // AES arithmetic for the reference key schedule.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Byte 0 of the key sits in bits [7:0]; each round key is packed the same way.
    task automatic aes_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]] ^ rc};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) fill_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    task automatic rand_keys();
        for (int r = 0; r < 11; r++) fill_rk[r] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic push_exp(input int c, input logic [127:0] e);
        if (c == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic do_read_exp(input int c, input int r, input logic [127:0] e);
        rd_round  = 4'(r);
        rd_req[c] = 1'b1;
        push_exp(c, e);
        tick();
        rd_req[c] = 1'b0;
    endtask

    task automatic do_read(input int c, input int r);
        logic [127:0] e;
        e = '0;
        if (r <= 10 && m_valid[c][m_active[c]]) e = m_key[c][m_active[c]][r];
        do_read_exp(c, r, e);
    endtask

    // gap < 0 selects random 0..1 idle cycles between beats.
    task automatic do_fill(input int c, input int bank, input int nbeats, input int gap, input bit sw_last);
        int           beats;
        int           g;
        bit           rej;
        logic [127:0] tmp;
        beats = 11 * wpk(c);
        rej   = (bank == m_active[c]) && (busy[c] || m_pend[c]);
        for (int b = 0; b < nbeats; b++) begin
            g = (b == 0) ? 0 : ((gap < 0) ? int'($urandom_range(1, 0)) : gap);
            repeat (g) tick();
            tmp       = fill_rk[b / wpk(c)];
            wr_dat    = (wpk(c) == 2) ? {64'h0, tmp[(b % 2) * 64 +: 64]} : tmp;
            wr_bank   = 3'(bank);
            en_wr[c]  = 1'b1;
            if (sw_last && b == beats - 1) begin
                sw_key[c] = 1'b1;
                sel_bank  = 3'(bank);
            end
            tick();
            en_wr[c]  = 1'b0;
            sw_key[c] = 1'b0;
            if (b == 0) begin
                chk("first-beat err pulse", 128'(g_err(c)), 128'(rej));
                if (rej) begin
                    check_state(c, "rejected fill");
                    tick();
                    chk("err pulse single cycle", 128'(g_err(c)), 128'(0));
                    return;
                end
                m_valid[c][bank] = 1'b0;
                chk("bank_valid cleared on first beat", 128'(g_vld(c)), 128'(m_valid[c]));
            end
            if (b == beats - 1) begin
                m_valid[c][bank] = 1'b1;
                for (int r = 0; r < 11; r++) m_key[c][bank][r] = fill_rk[r];
                chk("wr_done_pulse", 128'(g_done(c)), 128'(1));
                chk("final-beat err pulse", 128'(g_err(c)), 128'(sw_last));
                check_state(c, "fill done");
                tick();
                chk("wr_done_pulse single cycle", 128'(g_done(c)), 128'(0));
            end
        end
    endtask

    task automatic do_switch(input int c, input int bank);
        bit rej;
        rej = (bank >= nbk(c)) || !m_valid[c][bank];
        sw_key[c] = 1'b1;
        sel_bank  = 3'(bank);
        tick();
        sw_key[c] = 1'b0;
        if (!rej) begin
            if (busy[c]) begin
                m_pend[c]      = 1'b1;
                m_pend_bank[c] = bank;
            end else begin
                m_active[c] = bank;
                m_pend[c]   = 1'b0;
            end
        end
        chk($sformatf("switch->%0d err pulse", bank), 128'(g_err(c)), 128'(rej));
        check_state(c, "switch");
        tick();
        chk("switch err pulse single cycle", 128'(g_err(c)), 128'(0));
    endtask

    task automatic set_busy(input int c, input bit v);
        busy[c] = v;
        tick();
        if (!v && m_pend[c]) begin
            m_active[c] = m_pend_bank[c];
            m_pend[c]   = 1'b0;
        end
        check_state(c, "busy change");
    endtask

    task automatic do_reset();
        busy   = '0;
        en_wr  = '0;
        sw_key = '0;
        kill_n = 1'b0;
        tick();
        for (int c = 0; c < 2; c++) begin
            chk("reset rd_key", g_rd(c), 128'(0));
            chk("reset active_bank", 128'(g_act(c)), 128'(0));
            chk("reset bank_valid", 128'(g_vld(c)), 128'(0));
            chk("reset switch_pending", 128'(g_pend(c)), 128'(0));
            chk("reset wr_done_pulse", 128'(g_done(c)), 128'(0));
            chk("reset key_err_irq_pulse", 128'(g_err(c)), 128'(0));
            m_valid[c]  = '0;
            m_active[c] = 0;
            m_pend[c]   = 1'b0;
        end
        kill_n = 1'b1;
        tick();
    endtask

    // Monitor: every requested read is compared one edge after issue.
    initial begin
        forever begin
            @(posedge clk);
            mon_req = rd_req;
            #2;
            for (int c = 0; c < 2; c++) begin
                if (mon_req[c]) begin
                    if (((c == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rd_key[%0d]: read seen with no expected value queued", c);
                    end else begin
                        mon_exp = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk($sformatf("rd_key[%0d]", c), g_rd(c), mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int op;
        kill_n   = 1'b1;
        en_wr    = '0;
        sw_key   = '0;
        busy     = '0;
        wr_dat   = '0;
        wr_bank  = '0;
        sel_bank = '0;
        rd_round = '0;
        rd_req   = '0;
        build_sbox();
        tick();
        do_reset();

        // Switch to a bank never filled.
        do_switch(0, 1);

        // Known AES-128 schedule into bank 0.
        aes_expand(128'h0f0e0d0c0b0a09080706050403020100);
        do_fill(0, 0, 22, -1, 1'b0);
        do_switch(0, 0);
        do_read_exp(0, 0, 128'h0f0e0d0c0b0a09080706050403020100);
        do_read_exp(0, 10, 128'hc5302b4d8ba707f3174a94e37f1d1113);
        do_read(0, 5);
        do_read(0, 11);

        // Deferred switch while busy.
        rand_keys();
        do_fill(0, 1, 22, 2, 1'b0);
        set_busy(0, 1'b1);
        do_switch(0, 1);
        set_busy(0, 1'b0);
        do_read(0, 10);

        // Overwriting the active bank while busy is refused.
        set_busy(0, 1'b1);
        rand_keys();
        do_fill(0, 1, 22, 0, 1'b0);
        do_read(0, 3);
        set_busy(0, 1'b0);

        // Refill active bank while idle; switch on a bank's own final beat.
        rand_keys();
        do_fill(0, 1, 22, -1, 1'b0);
        do_read(0, 7);
        rand_keys();
        do_fill(0, 0, 22, -1, 1'b1);

        // Four banks, full-width beats, one idle cycle between beats.
        rand_keys();
        do_fill(1, 2, 11, 1, 1'b0);
        rand_keys();
        do_fill(1, 3, 11, 1, 1'b0);
        chk("bank_valid 4-bank", 128'(g_vld(1)), 128'(8'b0000_1100));
        do_switch(1, 2);
        do_read(1, 10);
        do_switch(1, 3);
        do_read(1, 10);
        do_read(1, 0);

        // Pending target kept on a bad request, replaced on a good one.
        set_busy(1, 1'b1);
        do_switch(1, 2);
        do_switch(1, 0);
        set_busy(1, 1'b0);
        set_busy(1, 1'b1);
        do_switch(1, 3);
        do_switch(1, 2);
        set_busy(1, 1'b0);
        do_read(1, 4);

        // Random traffic on the two-bank instance.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(4, 0);
            case (op)
                0: begin
                    rand_keys();
                    do_fill(0, $urandom_range(1, 0), 22, -1, 1'b0);
                end
                1: do_switch(0, $urandom_range(1, 0));
                2: set_busy(0, 1'($urandom_range(1, 0)));
                default: do_read(0, $urandom_range(15, 0));
            endcase
        end
        set_busy(0, 1'b0);

        // Reset in the middle of a fill, then a clean fill.
        rand_keys();
        do_fill(0, 0, 10, 0, 1'b0);
        do_reset();
        do_read(0, 2);
        rand_keys();
        do_fill(0, 0, 22, -1, 1'b0);
        do_switch(0, 0);
        do_read(0, 10);

        tick();
        tick();
        chk("scoreboard drained", 128'(exp_q0.size() + exp_q1.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_128_key_bank.md
AES_128_KEY_BANK -- requirements
Module: aes_128_key_bank

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of round-key sets held (legal 2..8).
REQ-002 SHALL have parameter WR_WIDTH, default 64, key write-port width (legal 64 or 128).
REQ-003 SHALL derive localparam BEATS = 1408/WR_WIDTH (22 or 11) and BW = $clog2(NUM_BANKS).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port kill_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en_wr, input, 1, write beat valid.
REQ-007 SHALL have port key_round_wr, input, WR_WIDTH, write beat data.
REQ-008 SHALL have port wr_bank, input, BW, target bank, sampled on the first beat of a fill only.
REQ-009 SHALL have port switch_key, input, 1, single-cycle request to change the active bank.
REQ-010 SHALL have port sel_bank, input, BW, bank requested, sampled with switch_key.
REQ-011 SHALL have port busy, input, 1, core encryption in flight.
REQ-012 SHALL have port rd_round, input, 4, round index requested by the core.
REQ-013 SHALL have port rd_key, output, 128, round key of the active bank.
REQ-014 SHALL have port active_bank, output, BW, bank currently feeding rd_key.
REQ-015 SHALL have port bank_valid, output, NUM_BANKS, per-bank complete-key-set flag.
REQ-016 SHALL have port switch_pending, output, 1, accepted switch awaiting busy low.
REQ-017 SHALL have port wr_done_pulse, output, 1, one-cycle pulse on the final beat of a fill.
REQ-018 SHALL have port key_err_irq_pulse, output, 1, one-cycle pulse on any rejected operation.

Function
REQ-019 Write FSM SHALL have states IDLE and FILL; IDLE->FILL on en_wr, FILL->IDLE on beat BEATS; beat counter 0..BEATS-1, increments only on en_wr, gaps between beats allowed.
REQ-020 Round key r SHALL be stored from beats in order: WR_WIDTH=64 -> beat 2r is bits [63:0], beat 2r+1 is bits [127:64]; WR_WIDTH=128 -> beat r is the full key.
REQ-021 First beat SHALL latch the target bank and clear its bank_valid; the final beat SHALL set it and assert wr_done_pulse in the following cycle.
REQ-022 A first beat targeting active_bank while busy=1 or switch_pending=1 SHALL be rejected: no storage change, FSM stays IDLE, key_err_irq_pulse asserted.
REQ-023 Writing the active bank while busy=0 SHALL be accepted; its bank_valid drops, and rd_key for that bank then reads 0 until the fill completes.
REQ-024 switch_key with bank_valid[sel_bank]=0, or with sel_bank equal to the bank being filled, SHALL be rejected with key_err_irq_pulse; a switch on the same cycle as that bank's final beat SHALL also be rejected.
REQ-025 Accepted switch with busy=0 SHALL update active_bank on the next edge; with busy=1 SHALL set switch_pending and update active_bank on the first edge with busy=0, then clear switch_pending.
REQ-026 A new switch_key while switch_pending=1 SHALL replace the pending target if valid, otherwise it SHALL be rejected and the old target kept.
REQ-027 rd_key SHALL be registered, one-cycle latency from rd_round, reflecting active_bank at sample time; rd_round > 10 SHALL return 0.
REQ-028 key_err_irq_pulse SHALL be a single cycle per rejected event; simultaneous rejects SHALL produce one pulse.

Reset
REQ-029 On kill_n low: rd_key=0, active_bank=0, bank_valid=0, switch_pending=0, wr_done_pulse=0, key_err_irq_pulse=0, FSM=IDLE, beat counter=0; key storage need not be cleared.
REQ-030 Reset mid-fill SHALL abandon the fill; that bank stays invalid after release.

Verification
REQ-031 WR_WIDTH=64, fill bank 0 with 22 beats for key 0f0e0d0c0b0a09080706050403020100 (low half first), switch to 0 -> bank_valid=01, rd_round=0 gives 0f0e0d0c0b0a09080706050403020100, rd_round=10 gives c5302b4d8ba707f3174a94e37f1d1113 one cycle later.
REQ-032 busy=1, switch_key to valid bank 1 -> switch_pending=1, active_bank stays 0; busy low -> active_bank=1 next edge, switch_pending=0.
REQ-033 switch_key to invalid bank 1 after reset -> key_err_irq_pulse one cycle, active_bank=0.
REQ-034 busy=1, first beat to active bank -> key_err_irq_pulse, bank_valid unchanged, subsequent rd_key unchanged.
REQ-035 kill_n low after beat 10 of 22 -> all outputs 0, bank_valid[target]=0; fresh 22-beat fill then completes with wr_done_pulse.
REQ-036 NUM_BANKS=4, WR_WIDTH=128: 11-beat fills into banks 2 and 3 with 1-cycle gaps -> bank_valid=1100, switching between them gives correct round-10 keys.
